eem16_proj2: RTL and testbench
==============================

Name: eem16_proj2

Overview:
- Registered 4-bit BCD to 7-segment decoder.
- Takes a binary digit on w,x,y,z, with w as the MSB, and drives the seven segment lines a..g of a single display digit.
- Sits between the digit-select/counter logic and the display pins.
- Outputs are registered, so the display is glitch-free and synchronous to the system clock.

Parameters:
- ACTIVE_LOW, default 0: 0 means a segment is lit when its output is 1 (common-cathode); 1 inverts all seven outputs (common-anode).
- HEX_MODE, default 0: 0 blanks codes 10-15; 1 displays them as hex glyphs A,b,C,d,E,F.

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- w  input  1  digit bit 3 (MSB, weight 8).
- x  input  1  digit bit 2 (weight 4).
- y  input  1  digit bit 1 (weight 2).
- z  input  1  digit bit 0 (LSB, weight 1).
- a  output  1  segment a: top.
- b  output  1  segment b: upper right.
- c  output  1  segment c: lower right.
- d  output  1  segment d: bottom.
- e  output  1  segment e: lower left.
- f  output  1  segment f: upper left.
- g  output  1  segment g: middle.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
  - Clock port is clk and reset port is rst.
  - All seven outputs come from flip-flops clocked by clk and reset by rst.
- Reset:
  - While rst=1, all segments are off immediately, without waiting for a clock edge.
  - "Off" is a..g = 0 when ACTIVE_LOW=0, and 1 when ACTIVE_LOW=1.
- Latency:
  - The code N = {w,x,y,z} is sampled on each rising clk edge.
  - The decoded pattern appears on a..g after that edge (1-cycle latency).
  - The pattern holds until the next edge.
  - A new code every cycle is supported, with no handshake.
- Decode table, logical values with 1 = segment lit, listed as a b c d e f g:
  - 0 = 1111110
  - 1 = 0110000
  - 2 = 1101101
  - 3 = 1111001
  - 4 = 0110011
  - 5 = 1011011
  - 6 = 1011111 (6 includes top segment a)
  - 7 = 1110000 (7 has no f)
  - 8 = 1111111
  - 9 = 1111011 (9 includes bottom segment d)
- Codes 10-15:
  - HEX_MODE=0: all seven segments off (blank).
  - HEX_MODE=1: A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Polarity: ACTIVE_LOW=1 inverts each bit at the register input, so the registered outputs are already inverted.
- Reset release:
  - Outputs stay blank until the first rising edge after rst falls.
  - That edge loads the decode of the inputs present at that edge.
- Reset asserted mid-operation: outputs go blank asynchronously and the previous digit is not retained.
- X/Z inputs: no requirement; decode need not be defined for them.
- Combinational input change between edges: no output change.

Test Plan:
- Assert rst=1 with inputs 1000 and clk running -> a..g=0000000 immediately and held while rst=1; release rst -> after the next edge a..g=1111111.
- Step N=1..9 then 0, one code per 20 ns (clk period 10 ns), ACTIVE_LOW=0 -> each code matches the table one cycle after it is sampled.
  - Checkpoints: N=1 gives 0110000, N=7 gives 1110000, N=0 gives 1111110.
- N=10..15 with HEX_MODE=0 -> 0000000 for each. Same codes with HEX_MODE=1 -> 10 gives 1110111, 15 gives 1000111.
- ACTIVE_LOW=1, N=8 -> 0000000; N=1 -> 1001111; during rst -> 1111111.
- Change the input from 0011 to 0101 mid-cycle, between edges -> the output stays 1111001 until the next edge, then becomes 1011011.
- Pulse rst while displaying N=2 (1101101), mid-cycle and asynchronous to clk -> the output goes to 0000000 before any clock edge, then reloads 1101101 on the first edge after release.

Source files
------------

// File: rtl/eem16_proj2.sv
// Registered 4-bit code to 7-segment decoder, one display digit.
// Segment polarity and hex-glyph display for codes 10-15 are set by parameters.
module eem16_proj2 #(
   parameter bit ACTIVE_LOW = 1'b0,
   parameter bit HEX_MODE   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic w,
   input  logic x,
   input  logic y,
   input  logic z,
   output logic a,
   output logic b,
   output logic c,
   output logic d,
   output logic e,
   output logic f,
   output logic g
);

   logic [3:0] code;
   logic [6:0] seg_lit;
   logic [6:0] seg_next;
   logic [6:0] seg_off;
   logic [6:0] seg_q;

   assign code = {w, x, y, z};

   // Bit order is {a,b,c,d,e,f,g}; 1 means the segment is lit.
   always_comb begin
      seg_lit = '0;
      unique case (code)
         4'd0:  seg_lit = 7'b1111110;
         4'd1:  seg_lit = 7'b0110000;
         4'd2:  seg_lit = 7'b1101101;
         4'd3:  seg_lit = 7'b1111001;
         4'd4:  seg_lit = 7'b0110011;
         4'd5:  seg_lit = 7'b1011011;
         4'd6:  seg_lit = 7'b1011111;
         4'd7:  seg_lit = 7'b1110000;
         4'd8:  seg_lit = 7'b1111111;
         4'd9:  seg_lit = 7'b1111011;
         4'd10: seg_lit = HEX_MODE ? 7'b1110111 : 7'b0000000;
         4'd11: seg_lit = HEX_MODE ? 7'b0011111 : 7'b0000000;
         4'd12: seg_lit = HEX_MODE ? 7'b1001110 : 7'b0000000;
         4'd13: seg_lit = HEX_MODE ? 7'b0111101 : 7'b0000000;
         4'd14: seg_lit = HEX_MODE ? 7'b1001111 : 7'b0000000;
         4'd15: seg_lit = HEX_MODE ? 7'b1000111 : 7'b0000000;
         default: seg_lit = '0;
      endcase
   end

   // Inversion happens before the register so the pins stay glitch-free.
   assign seg_next = ACTIVE_LOW ? ~seg_lit : seg_lit;
   assign seg_off  = ACTIVE_LOW ? '1 : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) seg_q <= seg_off;
      else     seg_q <= seg_next;
   end

   assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_eem16_proj2.sv
// Directed bench for eem16_proj2: decimal, hex and active-low variants side by side.
module tb_eem16_proj2;

   logic clk;
   logic rst;
   logic w, x, y, z;

   logic a0, b0, c0, d0, e0, f0, g0;
   logic a1, b1, c1, d1, e1, f1, g1;
   logic a2, b2, c2, d2, e2, f2, g2;
   logic [6:0] seg_dec, seg_hex, seg_al;

   int tests_run;
   int tests_failed;

   logic [6:0] exp_dec [0:15];
   logic [6:0] exp_hex [0:15];

   eem16_proj2 #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b0)) u_dec (
      .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
      .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0));

   eem16_proj2 #(.ACTIVE_LOW(1'b0), .HEX_MODE(1'b1)) u_hex (
      .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
      .a(a1), .b(b1), .c(c1), .d(d1), .e(e1), .f(f1), .g(g1));

   eem16_proj2 #(.ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) u_al (
      .clk(clk), .rst(rst), .w(w), .x(x), .y(y), .z(z),
      .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2));

   assign seg_dec = {a0, b0, c0, d0, e0, f0, g0};
   assign seg_hex = {a1, b1, c1, d1, e1, f1, g1};
   assign seg_al  = {a2, b2, c2, d2, e2, f2, g2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_code(input logic [3:0] n);
      {w, x, y, z} = n;
   endtask

   task automatic test_reset();
      set_code(4'd8);
      rst = 1'b1;
      #3;
      tests_run++;
      if (seg_dec !== 7'b0000000) begin
         tests_failed++;
         $display("FAIL reset_async_dec: got %b want 0000000", seg_dec);
      end
      tests_run++;
      if (seg_al !== 7'b1111111) begin
         tests_failed++;
         $display("FAIL reset_async_al: got %b want 1111111", seg_al);
      end
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if (seg_dec !== 7'b0000000) begin
         tests_failed++;
         $display("FAIL reset_held: got %b want 0000000", seg_dec);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      tests_run++;
      if (seg_dec !== 7'b0000000) begin
         tests_failed++;
         $display("FAIL reset_release_no_edge: got %b want 0000000", seg_dec);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (seg_dec !== 7'b1111111) begin
         tests_failed++;
         $display("FAIL reset_release_load: got %b want 1111111", seg_dec);
      end
   endtask

   task automatic test_decimal();
      logic [3:0] n;
      for (int unsigned i = 1; i <= 10; i++) begin
         n = (i == 10) ? 4'd0 : 4'(i);
         @(negedge clk);
         set_code(n);
         @(posedge clk);
         #1;
         tests_run++;
         if (seg_dec !== exp_dec[n]) begin
            tests_failed++;
            $display("FAIL decimal_%0d: got %b want %b", n, seg_dec, exp_dec[n]);
         end
         tests_run++;
         if (seg_hex !== exp_hex[n]) begin
            tests_failed++;
            $display("FAIL decimal_hexinst_%0d: got %b want %b", n, seg_hex, exp_hex[n]);
         end
         @(posedge clk);
      end
   endtask

   task automatic test_hex();
      for (int unsigned i = 10; i <= 15; i++) begin
         @(negedge clk);
         set_code(4'(i));
         @(posedge clk);
         #1;
         tests_run++;
         if (seg_dec !== 7'b0000000) begin
            tests_failed++;
            $display("FAIL blank_%0d: got %b want 0000000", i, seg_dec);
         end
         tests_run++;
         if (seg_hex !== exp_hex[i]) begin
            tests_failed++;
            $display("FAIL hex_%0d: got %b want %b", i, seg_hex, exp_hex[i]);
         end
         tests_run++;
         if (seg_al !== 7'b1111111) begin
            tests_failed++;
            $display("FAIL al_blank_%0d: got %b want 1111111", i, seg_al);
         end
      end
   endtask

   task automatic test_active_low();
      @(negedge clk);
      set_code(4'd8);
      @(posedge clk);
      #1;
      tests_run++;
      if (seg_al !== 7'b0000000) begin
         tests_failed++;
         $display("FAIL al_8: got %b want 0000000", seg_al);
      end
      @(negedge clk);
      set_code(4'd1);
      @(posedge clk);
      #1;
      tests_run++;
      if (seg_al !== 7'b1001111) begin
         tests_failed++;
         $display("FAIL al_1: got %b want 1001111", seg_al);
      end
   endtask

   task automatic test_midcycle_change();
      @(negedge clk);
      set_code(4'd3);
      @(posedge clk);
      #1;
      tests_run++;
      if (seg_dec !== 7'b1111001) begin
         tests_failed++;
         $display("FAIL mid_load3: got %b want 1111001", seg_dec);
      end
      #2;
      set_code(4'd5);
      #1;
      tests_run++;
      if (seg_dec !== 7'b1111001) begin
         tests_failed++;
         $display("FAIL mid_hold: got %b want 1111001", seg_dec);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (seg_dec !== 7'b1011011) begin
         tests_failed++;
         $display("FAIL mid_load5: got %b want 1011011", seg_dec);
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      set_code(4'd2);
      @(posedge clk);
      #1;
      tests_run++;
      if (seg_dec !== 7'b1101101) begin
         tests_failed++;
         $display("FAIL pulse_before: got %b want 1101101", seg_dec);
      end
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if (seg_dec !== 7'b0000000) begin
         tests_failed++;
         $display("FAIL pulse_async_clear: got %b want 0000000", seg_dec);
      end
      tests_run++;
      if (seg_al !== 7'b1111111) begin
         tests_failed++;
         $display("FAIL pulse_async_clear_al: got %b want 1111111", seg_al);
      end
      #2;
      rst = 1'b0;
      #1;
      tests_run++;
      if (seg_dec !== 7'b0000000) begin
         tests_failed++;
         $display("FAIL pulse_no_retain: got %b want 0000000", seg_dec);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (seg_dec !== 7'b1101101) begin
         tests_failed++;
         $display("FAIL pulse_reload: got %b want 1101101", seg_dec);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst = 1'b0;
      set_code(4'd0);

      exp_dec[0]  = 7'b1111110;  exp_dec[1]  = 7'b0110000;
      exp_dec[2]  = 7'b1101101;  exp_dec[3]  = 7'b1111001;
      exp_dec[4]  = 7'b0110011;  exp_dec[5]  = 7'b1011011;
      exp_dec[6]  = 7'b1011111;  exp_dec[7]  = 7'b1110000;
      exp_dec[8]  = 7'b1111111;  exp_dec[9]  = 7'b1111011;
      for (int unsigned i = 10; i <= 15; i++) exp_dec[i] = 7'b0000000;
      for (int unsigned i = 0; i <= 9; i++) exp_hex[i] = exp_dec[i];
      exp_hex[10] = 7'b1110111;  exp_hex[11] = 7'b0011111;
      exp_hex[12] = 7'b1001110;  exp_hex[13] = 7'b0111101;
      exp_hex[14] = 7'b1001111;  exp_hex[15] = 7'b1000111;

      #2;
      test_reset();
      test_decimal();
      test_hex();
      test_active_low();
      test_midcycle_change();
      test_async_reset();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
